fxp_alu_pipe: RTL
=================

# fxp_alu_pipe

Two-stage pipelined, width-parametrised signed fixed-point ALU with valid/ready handshaking on both sides. It adds MAX, ABS and a saturating multiply-accumulate register to the existing add/sub/mul/logic/sigmoid/rotate/min operation set. It sits between an operand source and a result consumer in the simulation datapath and can absorb consumer backpressure without losing results.

## Interface
- INT_W, 3, integer bits (including sign) of the Q format
- FRAC_W, 5, fraction bits
- DATA_W, INT_W+FRAC_W, operand/result width (derived; do not override)
- INST_W, 4, opcode width (fixed at 4)
- i_clk  input  1  clock, all state updates on rising edge
- i_rst_n  input  1  reset, synchronous, active-low
- i_valid  input  1  operation request
- o_ready  output  1  ALU accepts request this cycle
- i_inst  input  INST_W  opcode
- i_data_a  input  DATA_W  signed operand A
- i_data_b  input  DATA_W  signed operand B
- o_valid  output  1  result valid
- i_ready  input  1  consumer accepts result this cycle
- o_data  output  DATA_W  result
- o_sat  output  1  result was clipped to max/min (arithmetic ops only)

## Operation
- Q format: value = signed(x)/2^FRAC_W. MAX = 0111…1, MIN = 1000…0.
- Saturation: any arithmetic result outside [MIN, MAX] clips to the nearer bound and sets o_sat. Non-clipped results and non-arithmetic ops give o_sat=0.
- Opcodes:
  - 0 ADD: a+b, saturating.
  - 1 SUB: a-b, saturating.
  - 2 MUL: full 2·DATA_W product; add 2^(FRAC_W-1); arithmetic shift right FRAC_W (round half toward +inf); saturate.
  - 3 NAND: ~(a&b).
  - 4 XNOR: ~(a^b).
  - 5 SIGMOID, operand A only:
    - a ≥ 2.0 → 1.0.
    - a ≤ −2.0 → 0.
    - otherwise (a>>>2)+0.5, using an arithmetic shift.
  - 6 ROTR: rotate a right by (unsigned b) mod DATA_W; shift of 0 returns a.
  - 7 MIN: signed minimum.
  - 8 MAX: signed maximum.
  - 9 ABS: |a|; ABS(MIN) = MAX with o_sat=1.
  - 10 MAC: acc ← sat(acc + MUL(a,b)), where the MUL term is rounded and saturated first. o_data = new acc.
  - 11 ACC_CLR: acc ← 0; o_data = 0.
  - 12–15 reserved: o_data = 0, o_sat = 0; acc unchanged.
- Accumulator is a DATA_W signed register. It is read and written only in stage 2, so back-to-back MACs chain with no bubble.

## Timing
- Global advance: en = !o_valid || i_ready. o_ready = en. o_ready depends combinationally on i_ready; this path is intentional.
- Request transfer: occurs when i_valid && o_ready.
- Result transfer: occurs when o_valid && i_ready.
- Stage 1 (on en): capture opcode and operands; compute raw sum, difference, product, shift amount, compares and stage-1 valid.
- Stage 2 (on en): round, saturate, accumulate; register o_data/o_sat/o_valid.
- Latency: exactly 2 cycles from accepted request to o_valid when unstalled. Throughput is 1 op/cycle.
- Stall (o_valid && !i_ready):
  - Both stages hold.
  - o_data/o_sat stay stable.
  - acc is not updated.
  - No request is accepted.
- Bubbles: a cycle with en=1 and no transfer inserts a bubble. Bubbles do not touch acc.
- Reset (i_rst_n=0 at a clock edge), including mid-stream:
  - o_valid=0, o_data=0, o_sat=0, acc=0, stage-1 valid=0.
  - In-flight ops are discarded.
  - o_ready=1 in the first cycle after reset release.
- Simultaneous events: a result transfer and a request transfer in the same cycle are normal full-rate operation.

## Configuration
- FXP_ALU_MAC_EN defined:
  - Opcodes 10/11 and the accumulator are built.
- FXP_ALU_MAC_EN undefined:
  - No accumulator register.
  - Opcodes 10/11 behave as reserved: o_data=0, o_sat=0.
  - All other behaviour is identical.

## Test plan
Defaults INT_W=3, FRAC_W=5; 1.0 = 0x20.
- ADD 0x70+0x20 → 0x7F, o_sat=1. ADD 0x90+0xE0 → 0x80, o_sat=1. ADD 0x10+0x10 → 0x20, o_sat=0. Each result appears exactly 2 cycles after acceptance.
- MUL 0x30·0x30 → 0x48. MUL 0x60·0x60 → 0x7F with o_sat=1. MUL 0x01·0x10 → 0x01 (half rounds up). ABS 0x80 → 0x7F with o_sat=1.
- SIGMOID:
  - 0xE0 → 0x08 (checks the arithmetic shift).
  - 0x40 → 0x20.
  - 0xC0 → 0x00.
  - ROTR a=0x81 with b=1 or b=9 → 0xC0; b=8 → 0x81.
  - MIN(0x80,0x7F) → 0x80; MAX(0x80,0x7F) → 0x7F.
- MAC (with FXP_ALU_MAC_EN):
  - ACC_CLR, then MAC 0x20·0x20 on three consecutive cycles → 0x00, 0x20, 0x40, 0x60.
  - Eight such MACs saturate: last outputs 0x7F with o_sat=1.
  - Without the macro, all four outputs are 0x00.
- Backpressure: stream 6 ADDs at full rate while holding i_ready low for 3 cycles mid-stream.
  - o_ready drops in the same cycles.
  - o_data is stable during the hold.
  - All 6 results arrive in order with none lost or duplicated.
- Reset mid-stream: assert i_rst_n=0 for 1 cycle with 2 ops in flight and acc=0x40.
  - Next cycle: o_valid=0, o_data=0.
  - No stale result appears.
  - A following MAC 0x20·0x20 returns 0x20.

Source files
------------

// File: rtl/fxp_alu_pipe.sv
// Two-stage pipelined signed fixed-point ALU with valid/ready on both sides.
// Define FXP_ALU_MAC_EN to build the accumulator and the MAC/ACC_CLR opcodes.
module fxp_alu_pipe #(
    parameter int INT_W  = 3,
    parameter int FRAC_W = 5,
    parameter int DATA_W = INT_W + FRAC_W,
    parameter int INST_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [INST_W-1:0] i_inst,
    input  logic [DATA_W-1:0] i_data_a,
    input  logic [DATA_W-1:0] i_data_b,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_sat
);
    localparam int PROD_W = 2 * DATA_W + 1;
    localparam int SH_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic signed [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [PROD_W-1:0] MAX_W = {{(PROD_W-DATA_W){1'b0}}, MAX_V};
    localparam logic signed [PROD_W-1:0] MIN_W = {{(PROD_W-DATA_W){1'b1}}, MIN_V};
    localparam logic signed [PROD_W-1:0] ROUND_W = PROD_W'(1 << (FRAC_W - 1));
    localparam logic signed [PROD_W-1:0] TWO_W   = PROD_W'(2 * (1 << FRAC_W));
    localparam logic signed [PROD_W-1:0] NTWO_W  = -TWO_W;
    localparam logic [DATA_W-1:0] ONE_V  = DATA_W'(1 << FRAC_W);
    localparam logic [DATA_W-1:0] HALF_V = DATA_W'(1 << (FRAC_W - 1));

    localparam logic [INST_W-1:0] OP_ADD  = INST_W'(0);
    localparam logic [INST_W-1:0] OP_SUB  = INST_W'(1);
    localparam logic [INST_W-1:0] OP_MUL  = INST_W'(2);
    localparam logic [INST_W-1:0] OP_NAND = INST_W'(3);
    localparam logic [INST_W-1:0] OP_XNOR = INST_W'(4);
    localparam logic [INST_W-1:0] OP_SIG  = INST_W'(5);
    localparam logic [INST_W-1:0] OP_ROTR = INST_W'(6);
    localparam logic [INST_W-1:0] OP_MIN  = INST_W'(7);
    localparam logic [INST_W-1:0] OP_MAX  = INST_W'(8);
    localparam logic [INST_W-1:0] OP_ABS  = INST_W'(9);
`ifdef FXP_ALU_MAC_EN
    localparam logic [INST_W-1:0] OP_MAC  = INST_W'(10);
    localparam logic [INST_W-1:0] OP_CLR  = INST_W'(11);
`endif

    // Clip a wide signed value into the Q range; MSB of the return is the clip flag.
    function automatic logic [DATA_W:0] sat_wide(input logic signed [PROD_W-1:0] v);
        if (v > MAX_W)      sat_wide = {1'b1, MAX_V};
        else if (v < MIN_W) sat_wide = {1'b1, MIN_V};
        else                sat_wide = {1'b0, v[DATA_W-1:0]};
    endfunction

    // Handshake: a request moves when i_valid && o_ready, a result when o_valid && i_ready.
    // Both stages advance together on en, so a stalled output freezes the whole pipe.
    logic en;
    assign en      = !o_valid || i_ready;
    assign o_ready = en;

    logic signed [DATA_W-1:0] a_s, b_s;
    assign a_s = $signed(i_data_a);
    assign b_s = $signed(i_data_b);

    logic                     s1_valid;
    logic [INST_W-1:0]        s1_inst;
    logic signed [DATA_W-1:0] s1_a, s1_b;
    logic signed [PROD_W-1:0] s1_sum, s1_diff, s1_prod;
    logic [SH_W-1:0]          s1_shamt;
    logic                     s1_lt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_valid <= 1'b0;
            s1_inst  <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_sum   <= '0;
            s1_diff  <= '0;
            s1_prod  <= '0;
            s1_shamt <= '0;
            s1_lt    <= 1'b0;
        end else if (en) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_inst  <= i_inst;
                s1_a     <= a_s;
                s1_b     <= b_s;
                s1_sum   <= PROD_W'(a_s) + PROD_W'(b_s);
                s1_diff  <= PROD_W'(a_s) - PROD_W'(b_s);
                s1_prod  <= PROD_W'(a_s) * PROD_W'(b_s);
                s1_shamt <= SH_W'(i_data_b % DATA_W);
                s1_lt    <= a_s < b_s;
            end
        end
    end

    logic [DATA_W-1:0]        res;
    logic                     res_sat;
    logic signed [PROD_W-1:0] rnd;
    logic [DATA_W:0]          mul_r;
    logic signed [DATA_W-1:0] sig_sh;
    logic [2*DATA_W-1:0]      rot2;
`ifdef FXP_ALU_MAC_EN
    logic signed [DATA_W-1:0] acc, acc_next;
    logic                     acc_we;
    logic [DATA_W:0]          acc_sum;
`endif

    always_comb begin
        res     = '0;
        res_sat = 1'b0;
        rnd     = s1_prod + ROUND_W;
        mul_r   = sat_wide(rnd >>> FRAC_W);
        sig_sh  = s1_a >>> 2;
        rot2    = {s1_a, s1_a} >> s1_shamt;
`ifdef FXP_ALU_MAC_EN
        acc_next = acc;
        acc_we   = 1'b0;
        acc_sum  = sat_wide(PROD_W'(acc) + PROD_W'($signed(mul_r[DATA_W-1:0])));
`endif
        case (s1_inst)
            OP_ADD:  {res_sat, res} = sat_wide(s1_sum);
            OP_SUB:  {res_sat, res} = sat_wide(s1_diff);
            OP_MUL:  {res_sat, res} = mul_r;
            OP_NAND: res = ~(s1_a & s1_b);
            OP_XNOR: res = ~(s1_a ^ s1_b);
            OP_SIG: begin
                if (PROD_W'(s1_a) >= TWO_W)       res = ONE_V;
                else if (PROD_W'(s1_a) <= NTWO_W) res = '0;
                else                              res = sig_sh + HALF_V;
            end
            OP_ROTR: res = rot2[DATA_W-1:0];
            OP_MIN:  res = s1_lt ? s1_a : s1_b;
            OP_MAX:  res = s1_lt ? s1_b : s1_a;
            OP_ABS: begin
                if (s1_a == MIN_V) begin
                    res     = MAX_V;
                    res_sat = 1'b1;
                end else begin
                    res = s1_a[DATA_W-1] ? -s1_a : s1_a;
                end
            end
`ifdef FXP_ALU_MAC_EN
            OP_MAC: begin
                res      = acc_sum[DATA_W-1:0];
                res_sat  = acc_sum[DATA_W] | mul_r[DATA_W];
                acc_next = $signed(acc_sum[DATA_W-1:0]);
                acc_we   = 1'b1;
            end
            OP_CLR: begin
                acc_next = '0;
                acc_we   = 1'b1;
            end
`endif
            default: begin
                res     = '0;
                res_sat = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_sat   <= 1'b0;
`ifdef FXP_ALU_MAC_EN
            acc     <= '0;
`endif
        end else if (en) begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_data <= res;
                o_sat  <= res_sat;
`ifdef FXP_ALU_MAC_EN
                if (acc_we) acc <= acc_next;
`endif
            end
        end
    end
endmodule
